// File: rtl/hssi_tc_mailbox_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hssi_tc_mailbox_bridge                                                   |
// | Host mailbox (NOOP/RD/WR) to per-port traffic-controller register access |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hssi_tc_mailbox_bridge #(
  parameter int NUM_PORTS      = 8,
  parameter int TC_ADDR_W      = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        csr_wr,
  input  logic                        csr_rd,
  input  logic [4:0]                  csr_addr,
  input  logic [DATA_W-1:0]           csr_wrdata,
  output logic [DATA_W-1:0]           csr_rddata,
  output logic                        csr_rdvalid,
  output logic [NUM_PORTS-1:0]        tc_req_valid,
  output logic                        tc_wr,
  output logic [TC_ADDR_W-1:0]        tc_addr,
  output logic [DATA_W-1:0]           tc_wrdata,
  input  logic [NUM_PORTS-1:0]        tc_ack,
  input  logic [NUM_PORTS*DATA_W-1:0] tc_rddata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [4:0] OFF_CMD    = 5'h00;
  localparam logic [4:0] OFF_ADDR   = 5'h04;
  localparam logic [4:0] OFF_RDDATA = 5'h08;
  localparam logic [4:0] OFF_WRDATA = 5'h0C;
  localparam logic [4:0] OFF_PSEL   = 5'h10;

  localparam logic [1:0] CMD_RD = 2'd1;
  localparam logic [1:0] CMD_WR = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    wrdata_reg;
  logic [DATA_W-1:0]    rddata_reg;
  logic [3:0]           port_sel_reg;
  logic [3:0]           port_act;
  logic [1:0]           last_cmd;
  logic                 done;
  logic                 timeout;
  logic                 rejected;
  logic [CNT_W-1:0]     tmo_cnt;

  logic                 cmd_wr;
  logic [1:0]           cmd_code;
  logic                 cmd_xfer;
  logic                 port_ok;
  logic                 launch;
  logic                 fin_ack;
  logic                 fin_tmo;
  logic                 ack_sel;
  logic [DATA_W-1:0]    rddata_sel;
  logic [NUM_PORTS-1:0] onehot;
  logic [DATA_W-1:0]    status;
  logic [DATA_W-1:0]    rd_mux;

  // Port decode is done by comparison loops so a 4-bit select never indexes
  // past NUM_PORTS.
  always_comb begin
    onehot     = '0;
    ack_sel    = 1'b0;
    rddata_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_sel_reg == 4'(p)) onehot[p] = 1'b1;
      if (port_act == 4'(p)) begin
        ack_sel    = tc_ack[p];
        rddata_sel = tc_rddata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cmd_wr    = csr_wr && (csr_addr == OFF_CMD);
    cmd_code  = csr_wrdata[1:0];
    cmd_xfer  = cmd_wr && ((cmd_code == CMD_RD) || (cmd_code == CMD_WR));
    port_ok   = ({1'b0, port_sel_reg} < 5'(NUM_PORTS));
    launch    = 1'b0;
    fin_ack   = 1'b0;
    fin_tmo   = 1'b0;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_xfer && port_ok) begin
          launch    = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the final counted cycle still wins over the timeout.
        if (ack_sel) begin
          fin_ack   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fin_tmo   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    status      = '0;
    status[5:0] = {rejected, timeout, done, (state == ST_REQ), last_cmd};
    rd_mux      = '0;
    case (csr_addr)
      OFF_CMD:    rd_mux = status;
      OFF_ADDR:   rd_mux = addr_reg;
      OFF_RDDATA: rd_mux = rddata_reg;
      OFF_WRDATA: rd_mux = wrdata_reg;
      OFF_PSEL:   rd_mux[3:0] = port_sel_reg;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= '0;
      wrdata_reg   <= '0;
      rddata_reg   <= '0;
      port_sel_reg <= '0;
      port_act     <= '0;
      last_cmd     <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      rejected     <= 1'b0;
      tmo_cnt      <= '0;
      csr_rddata   <= '0;
      csr_rdvalid  <= 1'b0;
      tc_req_valid <= '0;
      tc_wr        <= 1'b0;
      tc_addr      <= '0;
      tc_wrdata    <= '0;
    end else begin
      csr_rdvalid <= csr_rd;
      csr_rddata  <= csr_rd ? rd_mux : '0;

      if (state == ST_IDLE) begin
        if (csr_wr) begin
          case (csr_addr)
            OFF_ADDR:   addr_reg     <= csr_wrdata;
            OFF_WRDATA: wrdata_reg   <= csr_wrdata;
            OFF_PSEL:   port_sel_reg <= csr_wrdata[3:0];
            default:    ;
          endcase
        end
        if (launch) begin
          port_act     <= port_sel_reg;
          last_cmd     <= cmd_code;
          done         <= 1'b0;
          timeout      <= 1'b0;
          rejected     <= 1'b0;
          tmo_cnt      <= '0;
          tc_req_valid <= onehot;
          tc_wr        <= (cmd_code == CMD_WR);
          tc_addr      <= addr_reg[TC_ADDR_W-1:0];
          tc_wrdata    <= wrdata_reg;
        end else if (cmd_xfer) begin
          rejected <= 1'b1;
          done     <= 1'b1;
        end else if (cmd_wr) begin
          done     <= 1'b0;
          timeout  <= 1'b0;
          rejected <= 1'b0;
        end
      end else begin
        if (cmd_xfer) rejected <= 1'b1;
        if (fin_ack) begin
          tc_req_valid <= '0;
          done         <= 1'b1;
          if (!tc_wr) rddata_reg <= rddata_sel;
        end else if (fin_tmo) begin
          tc_req_valid <= '0;
          done         <= 1'b1;
          timeout      <= 1'b1;
          if (!tc_wr) rddata_reg <= '1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hssi_tc_mailbox_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hssi_tc_mailbox_bridge                                                |
// | Scoreboard bench with a transaction-level mailbox model                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hssi_tc_mailbox_bridge;

  localparam int NP  = 8;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 16;

  localparam logic [4:0] A_CMD  = 5'h00;
  localparam logic [4:0] A_ADDR = 5'h04;
  localparam logic [4:0] A_RDD  = 5'h08;
  localparam logic [4:0] A_WRD  = 5'h0C;
  localparam logic [4:0] A_PSEL = 5'h10;

  logic             clk = 1'b0;
  logic             rst;
  logic             csr_wr, csr_rd;
  logic [4:0]       csr_addr;
  logic [DW-1:0]    csr_wrdata, csr_rddata;
  logic             csr_rdvalid;
  logic [NP-1:0]    tc_req_valid;
  logic             tc_wr;
  logic [AW-1:0]    tc_addr;
  logic [DW-1:0]    tc_wrdata;
  logic [NP-1:0]    tc_ack;
  logic [NP*DW-1:0] tc_rddata;

  hssi_tc_mailbox_bridge #(
    .NUM_PORTS(NP), .TC_ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .csr_wr(csr_wr), .csr_rd(csr_rd),
    .csr_addr(csr_addr), .csr_wrdata(csr_wrdata), .csr_rddata(csr_rddata),
    .csr_rdvalid(csr_rdvalid), .tc_req_valid(tc_req_valid), .tc_wr(tc_wr),
    .tc_addr(tc_addr), .tc_wrdata(tc_wrdata), .tc_ack(tc_ack),
    .tc_rddata(tc_rddata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NP-1:0] oh;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            len;
  } req_t;

  typedef struct {
    string         name;
    logic [DW-1:0] val;
  } rd_t;

  req_t req_q[$];
  rd_t  rd_q[$];

  // Mailbox model: register contents and status flags.
  logic [DW-1:0] m_addr, m_wrdata, m_rddata;
  logic [3:0]    m_psel;
  logic [1:0]    m_last;
  bit            m_done, m_tmo, m_rej, m_busy, m_cur_rd;

  int            resp_delay   = -1;
  logic [DW-1:0] resp_data    = '0;
  int            len_override = -1;
  bit            stray_req    = 1'b0;
  int            stray_port   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_addr = '0; m_wrdata = '0; m_rddata = '0; m_psel = '0; m_last = '0;
    m_done = 0; m_tmo = 0; m_rej = 0; m_busy = 0; m_cur_rd = 0;
  endtask

  function automatic int exp_len();
    if (len_override >= 0) return len_override;
    if (resp_delay >= 0 && resp_delay < TMO) return resp_delay + 1;
    return TMO;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [4:0] a);
    logic [DW-1:0] v;
    v = '0;
    case (a)
      A_CMD:  v[5:0] = {m_rej, m_tmo, m_done, m_busy, m_last};
      A_ADDR: v = m_addr;
      A_RDD:  v = m_rddata;
      A_WRD:  v = m_wrdata;
      A_PSEL: v[3:0] = m_psel;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [DW-1:0] d);
    logic [1:0] c;
    req_t r;
    c = d[1:0];
    if (m_busy) begin
      if (a == A_CMD && (c == 2'd1 || c == 2'd2)) m_rej = 1;
    end else begin
      case (a)
        A_ADDR: m_addr   = d;
        A_WRD:  m_wrdata = d;
        A_PSEL: m_psel   = d[3:0];
        A_CMD: begin
          if (c == 2'd1 || c == 2'd2) begin
            if (int'(m_psel) < NP) begin
              m_rej = 0; m_tmo = 0; m_done = 0; m_busy = 1;
              m_last = c; m_cur_rd = (c == 2'd1);
              r.oh = NP'(1) << m_psel; r.wr = (c == 2'd2);
              r.addr = m_addr[AW-1:0]; r.wd = m_wrdata; r.len = exp_len();
              req_q.push_back(r);
            end else begin
              m_rej = 1; m_done = 1;
            end
          end else begin
            m_rej = 0; m_tmo = 0; m_done = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    csr_wr = 1; csr_addr = a; csr_wrdata = d;
    m_write(a, d);
    @(negedge clk);
    csr_wr = 0;
  endtask

  task automatic host_read(input logic [4:0] a);
    rd_t e;
    @(negedge clk);
    csr_rd = 1; csr_addr = a;
    e.name = $sformatf("rd_%02h", a);
    e.val  = m_read(a);
    rd_q.push_back(e);
    @(negedge clk);
    csr_rd = 0;
  endtask

  task automatic finish_txn();
    int g;
    g = 0;
    while (tc_req_valid != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (tc_req_valid != 0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: valid 0x%0h still high, required 0", tc_req_valid);
    end
    m_busy = 0; m_done = 1;
    if (resp_delay >= 0 && resp_delay < TMO) begin
      if (m_cur_rd) m_rddata = resp_data;
    end else begin
      m_tmo = 1;
      if (m_cur_rd) m_rddata = '1;
    end
  endtask

  // Traffic-controller responder with random acks on non-selected ports.
  initial begin
    int vc;
    vc = 0;
    tc_ack = '0; tc_rddata = '0;
    forever begin
      @(negedge clk);
      tc_ack = NP'($urandom) & ~tc_req_valid;
      for (int p = 0; p < NP; p++) tc_rddata[p*DW +: DW] = $urandom;
      if (stray_req) begin
        tc_ack[stray_port] = 1'b1;
        tc_rddata[stray_port*DW +: DW] = 32'hDEAD_BEEF;
        stray_req = 0;
      end
      if (tc_req_valid != 0) begin
        if (vc == resp_delay) begin
          for (int p = 0; p < NP; p++) begin
            if (tc_req_valid[p]) begin
              tc_ack[p] = 1'b1;
              tc_rddata[p*DW +: DW] = resp_data;
            end
          end
        end
        vc++;
      end else begin
        vc = 0;
      end
    end
  end

  // Request monitor.
  initial begin
    req_t cur;
    bit   active;
    int   cnt;
    active = 0; cnt = 0;
    cur = '{oh: '0, wr: 1'b0, addr: '0, wd: '0, len: 0};
    forever begin
      @(negedge clk);
      if (tc_req_valid != 0) begin
        if (!active) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", 64'(tc_req_valid), 64'd0);
            cur = '{oh: tc_req_valid, wr: tc_wr, addr: tc_addr, wd: tc_wrdata, len: -1};
          end else begin
            cur = req_q.pop_front();
          end
          active = 1; cnt = 0;
        end
        chk("req_fields", {tc_req_valid, tc_wr, tc_addr, tc_wrdata},
            {cur.oh, cur.wr, cur.addr, cur.wd});
        cnt++;
      end else if (active) begin
        chk("req_len", 64'(cnt), 64'(cur.len));
        active = 0;
      end
    end
  end

  // Host read-response monitor.
  initial begin
    rd_t e;
    forever begin
      @(negedge clk);
      if (csr_rdvalid === 1'b1) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: got data 0x%0h, required no response", csr_rddata);
        end else begin
          e = rd_q.pop_front();
          chk(e.name, 64'(csr_rddata), 64'(e.val));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1; csr_wr = 0; csr_rd = 0; csr_addr = '0; csr_wrdata = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(tc_req_valid), 64'd0);
    chk("rst_tc_wr",     64'(tc_wr),        64'd0);
    chk("rst_tc_addr",   64'(tc_addr),      64'd0);
    chk("rst_tc_wrdata", 64'(tc_wrdata),    64'd0);
    chk("rst_rdvalid",   64'(csr_rdvalid),  64'd0);
    chk("rst_rddata",    64'(csr_rddata),   64'd0);
    rst = 0;
    host_read(A_CMD); host_read(A_ADDR); host_read(A_RDD);
    host_read(A_WRD); host_read(A_PSEL); host_read(5'h14);

    // Write to port 2, ack in the fourth valid cycle.
    resp_delay = 3;
    host_write(A_PSEL, 2); host_write(A_ADDR, 32'h0003);
    host_write(A_WRD, 32'hA5A5_0001); host_write(A_CMD, 2);
    finish_txn();
    host_read(A_CMD); host_read(A_WRD);

    // Read from port 5.
    resp_delay = 0; resp_data = 32'h0000_1234;
    host_write(A_PSEL, 5); host_write(A_ADDR, 32'h0100); host_write(A_CMD, 1);
    finish_txn();
    host_read(A_RDD); host_read(A_CMD);

    // Timeout on port 1.
    resp_delay = -1;
    host_write(A_PSEL, 1); host_write(A_CMD, 1);
    finish_txn();
    host_read(A_RDD); host_read(A_CMD);

    // Ack in the same cycle the timeout would fire: ack wins.
    resp_delay = TMO - 1; resp_data = 32'h0BAD_F00D;
    host_write(A_PSEL, 7); host_write(A_CMD, 1);
    finish_txn();
    host_read(A_CMD); host_read(A_RDD);

    // Busy rejection: writes during an in-flight read.
    resp_delay = 12; resp_data = 32'hCAFE_0042;
    host_write(A_PSEL, 3); host_write(A_ADDR, 32'h0040); host_write(A_CMD, 1);
    host_write(A_CMD, 2); host_write(A_ADDR, 32'h0055); host_write(A_PSEL, 6);
    host_read(A_CMD);
    finish_txn();
    host_read(A_CMD); host_read(A_ADDR); host_read(A_PSEL); host_read(A_RDD);

    // Reset during REQ followed by a stray ack from the aborted port.
    resp_delay = -1; len_override = 2;
    host_write(A_PSEL, 4); host_write(A_CMD, 2);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; m_reset();
    chk("rst_mid_req_valid", 64'(tc_req_valid), 64'd0);
    @(negedge clk); stray_port = 4; stray_req = 1;
    repeat (3) @(negedge clk);
    len_override = -1;
    host_read(A_CMD); host_read(A_RDD); host_read(A_ADDR); host_read(A_PSEL);

    // Out-of-range port, then NOOP and code 3 clearing the flags.
    host_write(A_PSEL, 9); host_write(A_CMD, 1);
    host_read(A_CMD);
    host_write(A_CMD, 3); host_read(A_CMD);
    host_write(A_PSEL, 15); host_write(A_CMD, 2); host_read(A_CMD);
    host_write(A_CMD, 0); host_read(A_CMD);
    host_write(5'h14, 32'hFFFF_FFFF); host_read(5'h14);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 16));
      resp_delay = (r == 16) ? -1 : r;
      resp_data  = $urandom;
      host_write(A_PSEL, $urandom_range(0, 9));
      host_write(A_ADDR, $urandom);
      host_write(A_WRD, $urandom);
      host_write(A_CMD, $urandom_range(0, 3));
      if (m_busy) begin
        if ($urandom_range(0, 1) == 1) host_write(A_CMD, $urandom_range(1, 2));
        finish_txn();
      end
      host_read(A_CMD);
      host_read(A_RDD);
      if (i % 5 == 0) host_read(A_ADDR);
    end

    repeat (5) @(negedge clk);
    chk("rd_q_empty",  64'(rd_q.size()),  64'd0);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
